alu_op_issuer: RTL

- Synthesizable initiator for the ALU's multicycle bitwise units (x/y operand inputs, done/sum outputs).
- Buffers operand pairs in a small command FIFO and issues them one at a time to a unit.
- Holds operands stable until the unit asserts done, captures sum, and returns it through a valid/ready result port.
- Guards every operation with a timeout.

---
 rtl/alu_op_issuer_if.sv | 33 +++
 rtl/alu_op_issuer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer_if.sv
// Handshake bundle between the ALU op issuer and its environment.
// Groups the command port, the multicycle unit port and the result port.
// master: command source, unit and result sink side.
// slave: the issuer itself.
interface alu_op_issuer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [WIDTH-1:0] unit_x;
    logic [WIDTH-1:0] unit_y;
    logic             unit_start;
    logic             unit_done;
    logic [WIDTH-1:0] unit_sum;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_timeout;

    modport master (
        output cmd_valid, cmd_a, cmd_b, unit_done, unit_sum, res_ready,
        input  cmd_ready, unit_x, unit_y, unit_start,
        input  res_valid, res_data, res_timeout
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, unit_done, unit_sum, res_ready,
        output cmd_ready, unit_x, unit_y, unit_start,
        output res_valid, res_data, res_timeout
    );
endinterface

// File: rtl/alu_op_issuer.sv
// Issues buffered operand pairs to a multicycle ALU unit, one at a time,
// and returns each result (or a timeout abort) in command order.
// Ports: clk, rst (sync, active high), bus (alu_op_issuer_if.slave:
// cmd_* command FIFO input, unit_* unit interface, res_* result output),
// busy (FSM active or FIFO holding commands).
module alu_op_issuer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    alu_op_issuer_if.slave bus,
    output logic           busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             full_q;
    logic             empty;
    logic             push;
    logic             pop;

    logic [CW-1:0]    tcnt;
    logic             cap_sum;
    logic             cap_to;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] res_q;
    logic             to_q;

    assign empty     = (count == '0);
    assign push      = bus.cmd_valid && !full_q;
    assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

    // Ready comes from the registered full flag only, so a pop in the
    // same cycle does not make room until the next cycle.
    assign bus.cmd_ready   = !full_q;
    assign bus.unit_x      = x_q;
    assign bus.unit_y      = y_q;
    assign bus.unit_start  = (state == ISSUE);
    assign bus.res_valid   = (state == HOLD);
    assign bus.res_data    = res_q;
    assign bus.res_timeout = to_q;
    assign busy            = (state != IDLE) || !empty;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        cap_sum   = 1'b0;
        cap_to    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                // Completion wins over a timeout landing on the same cycle.
                if (bus.unit_done) begin
                    cap_sum   = 1'b1;
                    state_nxt = HOLD;
                end else if (tcnt == CW'(TIMEOUT - 1)) begin
                    cap_to    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= bus.cmd_a;
            mem_b[wr_ptr] <= bus.cmd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
            tcnt   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            res_q  <= '0;
            to_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            full_q <= (count_nxt == (AW+1)'(DEPTH));
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                x_q    <= mem_a[rd_ptr];
                y_q    <= mem_b[rd_ptr];
            end
            if (state == ISSUE) begin
                tcnt <= '0;
            end else if (state == WAIT) begin
                tcnt <= tcnt + CW'(1);
            end
            if (cap_sum) begin
                res_q <= bus.unit_sum;
                to_q  <= 1'b0;
            end else if (cap_to) begin
                res_q <= '0;
                to_q  <= 1'b1;
            end
        end
    end
endmodule
